number_hit_detector: RTL and testbench
======================================

// Module: number_hit_detector
// PURPOSE
//  Consumer end of the number display outputs. Merges player and per-number drawing requests into one VGA pixel.
//  Detects player/number pixel overlap, latched per frame.
//  Reports at most one hit per frame back to the number display as a 1-cycle singleHit pulse.
//  The pulse carries the index of the hit number. Sits between the number display, the player object and the VGA mux.
// PARAMETERS
//  NUM_COUNT       12     number of number objects (width of numbersDR)
//  LOCKOUT_FRAMES  2      frames after a reported hit during which new overlaps are ignored (0 = none)
//  BG_RGB          8'h00  RGB driven when no object requests the pixel
// PORTS
//  clk            in   1                   system clock
//  resetN         in   1                   async active-low reset
//  startOfFrame   in   1                   1-cycle strobe at first pixel of each frame
//  playerDR       in   1                   player drawing request for current pixel
//  playerRGB      in   8                   player pixel colour
//  numbersDR      in   NUM_COUNT           per-number drawing requests
//  numbersRGB     in   [NUM_COUNT][8]      per-number pixel colours
//  RGBout         out  8                   merged pixel colour (registered)
//  drawingRequest out  1                   any object drawn this pixel (registered)
//  singleHit      out  1                   1-cycle hit pulse to number display
//  hitIndex       out  $clog2(NUM_COUNT)   index of reported number, valid with singleHit, held until next pulse
// BEHAVIOUR
//  Reset (async, resetN=0): RGBout=BG_RGB, drawingRequest=0, singleHit=0, hitIndex=0, hitVec=0, state=ARMED, lockCnt=0.
//  Pixel mux, latency 1 clk:
//   - playerDR wins; otherwise lowest-index numbersDR[i]; otherwise BG_RGB.
//   - drawingRequest = playerDR | (|numbersDR).
//  Overlap vector: ovl[i] = playerDR & numbersDR[i]; combinational, not registered.
//  FSM states:
//   - ARMED: hitVec |= ovl each cycle.
//       On startOfFrame with hitVec!=0: next clk singleHit=1, hitIndex=lowest set bit of hitVec, hitVec<=0.
//       Then lockCnt<=LOCKOUT_FRAMES; go to LOCKOUT, or stay ARMED when LOCKOUT_FRAMES==0.
//       On startOfFrame with hitVec==0: no pulse, stay ARMED.
//   - LOCKOUT: ovl ignored; hitVec held at 0.
//       Each startOfFrame decrements lockCnt. On the strobe where lockCnt==1, go to ARMED.
//  singleHit is high exactly 1 cycle, only in the cycle after a startOfFrame; at most one pulse per frame.
//  Simultaneous startOfFrame and ovl in ARMED: that cycle's ovl is excluded from the evaluated frame.
//   It seeds the new frame's hitVec (hitVec <= ovl).
//  Several numbers overlapped in one frame: only the lowest index is reported; the rest are discarded.
//  Overlaps only count while playerDR and numbersDR are high in the same cycle; no spatial tolerance.
//  Reset mid-frame or mid-lockout: pending hits are lost; no pulse is issued after reset until a new full evaluation.
// CONFIGURATION
//  NUMBER_HIT_COUNT_EN defined:
//   - adds output hitCount [7:0]. It increments by 1 on every singleHit pulse, saturates at 8'hFF, and resets to 0.
//  Undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package number_hit_pkg holds:
//   - typedef enum {ARMED, LOCKOUT} hit_state_t;
//   - NUM_COUNT_DEFAULT = 12;
//   - function lowest_set_idx(vector) shared by the mux and the hit encoder.
//  One sub-module: number_pixel_mux, the registered priority RGB/drawingRequest mux.
//   The FSM, hitVec and lockCnt stay in the top.
// TESTING
//  1. Reset, no DR for 3 frames -> RGBout=8'h00, drawingRequest=0, singleHit never asserted.
//  2. playerDR=1, playerRGB=8'hE0 and numbersDR[3]=1, numbersRGB[3]=8'h1C in the same cycle:
//     RGBout=8'hE0 one clk later. At the next startOfFrame, singleHit pulses once with hitIndex=3.
//  3. Overlaps on numbers 7 and 2 in the same frame -> one pulse, hitIndex=2.
//  4. LOCKOUT_FRAMES=2, overlap persists every frame:
//     pulses after frames 1 and 4 only; frames 2-3 are ignored.
//  5. Overlap in the same cycle as startOfFrame -> no pulse at that strobe; pulse at the following strobe.
//  6. resetN low mid-frame after an overlap -> all outputs at reset values; no pulse at the next strobe.
//     With NUMBER_HIT_COUNT_EN, hitCount=0 after reset and reads 3 after 3 pulses.

Source files
------------

// File: rtl/number_hit_detector_pkg.sv
// Shared types, defaults and the lowest-set-bit helper for the number hit detector.
package number_hit_pkg;

  localparam int NUM_COUNT_DEFAULT = 12;
  localparam int MAX_VEC_W         = 32;

  typedef enum logic {ARMED, LOCKOUT} hit_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set_idx(input logic [MAX_VEC_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/number_hit_detector_if.sv
// Bundle between number display / player / VGA mux and the hit detector.
// hitCount exists only when NUMBER_HIT_COUNT_EN is defined.
interface number_hit_if
  import number_hit_pkg::*;
#(
  parameter int NUM_COUNT = NUM_COUNT_DEFAULT
);
  localparam int IDX_W = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;

  logic                      startOfFrame;
  logic                      playerDR;
  logic [7:0]                playerRGB;
  logic [NUM_COUNT-1:0]      numbersDR;
  logic [NUM_COUNT-1:0][7:0] numbersRGB;
  logic [7:0]                RGBout;
  logic                      drawingRequest;
  logic                      singleHit;
  logic [IDX_W-1:0]          hitIndex;
`ifdef NUMBER_HIT_COUNT_EN
  logic [7:0]                hitCount;
`endif

  modport master (
    output startOfFrame, playerDR, playerRGB, numbersDR, numbersRGB,
`ifdef NUMBER_HIT_COUNT_EN
    input  hitCount,
`endif
    input  RGBout, drawingRequest, singleHit, hitIndex
  );

  modport slave (
    input  startOfFrame, playerDR, playerRGB, numbersDR, numbersRGB,
`ifdef NUMBER_HIT_COUNT_EN
    output hitCount,
`endif
    output RGBout, drawingRequest, singleHit, hitIndex
  );

endinterface

// File: rtl/number_hit_detector_pixel_mux.sv
// Registered priority pixel mux: player first, then lowest-index number, else background.
module number_pixel_mux
  import number_hit_pkg::*;
#(
  parameter int          NUM_COUNT = NUM_COUNT_DEFAULT,
  parameter logic [7:0]  BG_RGB    = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      player_dr_i,
  input  logic [7:0]                player_rgb_i,
  input  logic [NUM_COUNT-1:0]      numbers_dr_i,
  input  logic [NUM_COUNT-1:0][7:0] numbers_rgb_i,
  output logic [7:0]                rgb_o,
  output logic                      dr_o
);
  localparam int IDX_W = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;

  logic [IDX_W-1:0] num_idx;
  logic [7:0]       rgb_d, rgb_q;
  logic             dr_d, dr_q;

  assign num_idx = IDX_W'(lowest_set_idx(MAX_VEC_W'(numbers_dr_i)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rgb_d = BG_RGB;
    dr_d  = player_dr_i | (|numbers_dr_i);
    if (player_dr_i)        rgb_d = player_rgb_i;
    else if (|numbers_dr_i) rgb_d = numbers_rgb_i[num_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= BG_RGB;
      dr_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      dr_q  <= dr_d;
    end
  end

  assign rgb_o = rgb_q;
  assign dr_o  = dr_q;

endmodule

// File: rtl/number_hit_detector.sv
// Player/number overlap detector: one hit pulse per frame with post-hit frame lockout.
// Optional saturating hit counter enabled by NUMBER_HIT_COUNT_EN.
module number_hit_detector
  import number_hit_pkg::*;
#(
  parameter int         NUM_COUNT      = NUM_COUNT_DEFAULT,
  parameter int         LOCKOUT_FRAMES = 2,
  parameter logic [7:0] BG_RGB         = 8'h00
) (
  input  logic          clk,
  input  logic          resetN,
  number_hit_if.slave   bus
);
  localparam int IDX_W  = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;
  localparam int LOCK_W = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;

  hit_state_t           state_d, state_q;
  logic [NUM_COUNT-1:0] ovl;
  logic [NUM_COUNT-1:0] hit_vec_d, hit_vec_q;
  logic [LOCK_W-1:0]    lock_cnt_d, lock_cnt_q;
  logic                 single_hit_d, single_hit_q;
  logic [IDX_W-1:0]     hit_index_d, hit_index_q;
  logic [7:0]           rgb;
  logic                 dr;

  number_pixel_mux #(
    .NUM_COUNT (NUM_COUNT),
    .BG_RGB    (BG_RGB)
  ) u_pixel_mux (
    .clk           (clk),
    .rst_n         (resetN),
    .player_dr_i   (bus.playerDR),
    .player_rgb_i  (bus.playerRGB),
    .numbers_dr_i  (bus.numbersDR),
    .numbers_rgb_i (bus.numbersRGB),
    .rgb_o         (rgb),
    .dr_o          (dr)
  );

  assign ovl = {NUM_COUNT{bus.playerDR}} & bus.numbersDR;

  always_comb begin
    state_d      = state_q;
    hit_vec_d    = hit_vec_q;
    lock_cnt_d   = lock_cnt_q;
    single_hit_d = 1'b0;
    hit_index_d  = hit_index_q;
    unique case (state_q)
      ARMED: begin
        if (!bus.startOfFrame) begin
          hit_vec_d = hit_vec_q | ovl;
        end else begin
          // The strobe cycle's overlap belongs to the frame that is just starting.
          hit_vec_d = ovl;
          if (|hit_vec_q) begin
            single_hit_d = 1'b1;
            hit_index_d  = IDX_W'(lowest_set_idx(MAX_VEC_W'(hit_vec_q)));
            lock_cnt_d   = LOCK_W'(LOCKOUT_FRAMES);
            if (LOCKOUT_FRAMES != 0) begin
              state_d   = LOCKOUT;
              hit_vec_d = '0;
            end
          end
        end
      end
      LOCKOUT: begin
        hit_vec_d = '0;
        if (bus.startOfFrame) begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
          if (lock_cnt_q == LOCK_W'(1)) state_d = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ARMED;
      hit_vec_q    <= '0;
      lock_cnt_q   <= '0;
      single_hit_q <= 1'b0;
      hit_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      hit_vec_q    <= hit_vec_d;
      lock_cnt_q   <= lock_cnt_d;
      single_hit_q <= single_hit_d;
      hit_index_q  <= hit_index_d;
    end
  end

`ifdef NUMBER_HIT_COUNT_EN
  logic [7:0] hit_count_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                  hit_count_q <= 8'h00;
    else if (single_hit_d && hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'h01;
  end

  assign bus.hitCount = hit_count_q;
`endif

  assign bus.RGBout         = rgb;
  assign bus.drawingRequest = dr;
  assign bus.singleHit      = single_hit_q;
  assign bus.hitIndex       = hit_index_q;

endmodule

// File: tb/tb_number_hit_detector.sv
// Directed bench for number_hit_detector (NUM_COUNT=12, LOCKOUT_FRAMES=2, BG_RGB=0).
// hitCount checks are compiled in when NUMBER_HIT_COUNT_EN is defined.
module tb_number_hit_detector;
  import number_hit_pkg::*;

  localparam int N = 12;

  logic clk = 1'b0;
  logic resetN;
  int   passed = 0;
  int   total  = 0;
  int   pcnt   = 0;

  always #5 clk = ~clk;

  number_hit_if #(.NUM_COUNT(N)) bus ();

  number_hit_detector #(
    .NUM_COUNT      (N),
    .LOCKOUT_FRAMES (2),
    .BG_RGB         (8'h00)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always @(negedge clk) if (bus.singleHit === 1'b1) pcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.startOfFrame = 1'b0;
    bus.playerDR     = 1'b0;
    bus.playerRGB    = 8'h00;
    bus.numbersDR    = '0;
  endtask

  task automatic strobe();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic idle_frame();
    strobe();
    repeat (4) tick();
  endtask

  task automatic overlap(input int idx);
    bus.playerDR       = 1'b1;
    bus.playerRGB      = 8'hE0;
    bus.numbersDR      = '0;
    bus.numbersDR[idx] = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) bus.numbersRGB[i] = 8'(16 + 4 * i);
    resetN = 1'b0;
    repeat (2) tick();
    check("rst_rgb", bus.RGBout, 8'h00);
    check("rst_dr", bus.drawingRequest, 1'b0);
    check("rst_hit", bus.singleHit, 1'b0);
    check("rst_idx", bus.hitIndex, 4'd0);
`ifdef NUMBER_HIT_COUNT_EN
    check("rst_cnt", bus.hitCount, 8'h00);
`endif
    resetN = 1'b1;
    tick();

    // 1: three empty frames
    repeat (3) begin
      strobe();
      check("t1_no_hit", bus.singleHit, 1'b0);
      repeat (4) tick();
    end
    check("t1_pcnt", pcnt, 0);
    check("t1_rgb", bus.RGBout, 8'h00);
    check("t1_dr", bus.drawingRequest, 1'b0);

    // 2: player over number 3, plus mux priority
    bus.playerDR = 1'b1; bus.playerRGB = 8'hE0; bus.numbersDR[3] = 1'b1;
    tick();
    check("t2_rgb_player", bus.RGBout, 8'hE0);
    check("t2_dr_player", bus.drawingRequest, 1'b1);
    idle_inputs();
    bus.numbersDR[5] = 1'b1; bus.numbersDR[9] = 1'b1;
    tick();
    check("t2_rgb_low_num", bus.RGBout, 8'h24);
    check("t2_dr_num", bus.drawingRequest, 1'b1);
    idle_inputs();
    tick();
    check("t2_rgb_bg", bus.RGBout, 8'h00);
    check("t2_dr_bg", bus.drawingRequest, 1'b0);
    strobe();
    check("t2_hit", bus.singleHit, 1'b1);
    check("t2_idx", bus.hitIndex, 4'd3);
    tick();
    check("t2_hit_1cyc", bus.singleHit, 1'b0);
    check("t2_idx_held", bus.hitIndex, 4'd3);
    repeat (2) idle_frame();

    // 3: numbers 7 and 2 in one frame
    overlap(7);
    tick();
    overlap(2);
    strobe();
    check("t3_hit", bus.singleHit, 1'b1);
    check("t3_idx", bus.hitIndex, 4'd2);
    tick();
    check("t3_hit_1cyc", bus.singleHit, 1'b0);
    repeat (2) idle_frame();
    check("t3_pcnt", pcnt, 2);

    // 4: persistent overlap with 2-frame lockout: pulses after frames 1 and 4
    for (int f = 1; f <= 5; f++) begin
      repeat (2) overlap(6);
      strobe();
      check($sformatf("t4_frame%0d", f), bus.singleHit, (f == 1 || f == 4) ? 1'b1 : 1'b0);
      if (f == 4) check("t4_idx", bus.hitIndex, 4'd6);
      tick();
    end
    idle_frame();
    check("t4_pcnt", pcnt, 4);

    // 5: overlap coincident with the strobe seeds the next frame
    bus.playerDR = 1'b1; bus.playerRGB = 8'hE0; bus.numbersDR[4] = 1'b1;
    bus.startOfFrame = 1'b1;
    tick();
    idle_inputs();
    check("t5_no_hit", bus.singleHit, 1'b0);
    repeat (3) tick();
    strobe();
    check("t5_hit", bus.singleHit, 1'b1);
    check("t5_idx", bus.hitIndex, 4'd4);
    repeat (2) idle_frame();

    // 6: reset mid-frame drops the pending hit
    overlap(8);
    check("t6_rgb_pre", bus.RGBout, 8'hE0);
    resetN = 1'b0;
    #1;
    check("t6_rgb", bus.RGBout, 8'h00);
    check("t6_dr", bus.drawingRequest, 1'b0);
    check("t6_hit", bus.singleHit, 1'b0);
    check("t6_idx", bus.hitIndex, 4'd0);
`ifdef NUMBER_HIT_COUNT_EN
    check("t6_cnt_rst", bus.hitCount, 8'h00);
`endif
    tick();
    resetN = 1'b1;
    tick();
    strobe();
    check("t6_no_hit", bus.singleHit, 1'b0);
    check("t6_pcnt", pcnt, 5);

`ifdef NUMBER_HIT_COUNT_EN
    repeat (3) begin
      overlap(1);
      strobe();
      repeat (2) idle_frame();
    end
    check("cnt_three", bus.hitCount, 8'h03);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
